// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory-wait hold with timeout.
// Optional stall-cycle statistics counter enabled by defining HAZARD_STATS_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_Mread,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    input  logic        mem_busy,
    output logic        PC_write,
    output logic        IFID_write,
    output logic        IDEX_write,
    output logic        IFID_flush,
    output logic        IDEX_flush,
    output logic [1:0]  state,
    output logic        timeout_err,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } state_e;

    localparam logic [1:0] FLUSH_N   = FLUSH_CYCLES[1:0];
    localparam logic [7:0] TIMEOUT_N = MEM_TIMEOUT[7:0];

    state_e     state_q, state_d;
    logic [1:0] flush_cnt_q, flush_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;
    logic       load_use;

    assign load_use = ex_Mread && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = '0;
        timeout_d   = timeout_q;
        PC_write    = 1'b1;
        IFID_write  = 1'b1;
        IDEX_write  = 1'b1;
        IFID_flush  = 1'b0;
        IDEX_flush  = 1'b0;

        if (mem_busy) begin
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_write  = 1'b0;
            state_d     = MEM_WAIT;
            flush_cnt_d = '0;
            // Only cycles actually spent in MEM_WAIT count toward the timeout.
            if (state_q == MEM_WAIT) begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (wait_cnt_d == TIMEOUT_N) begin
                    timeout_d  = 1'b1;
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
        end else if (ex_branch_taken) begin
            IFID_flush  = 1'b1;
            IDEX_flush  = 1'b1;
            flush_cnt_d = 2'd1;
            state_d     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (load_use) begin
                        PC_write   = 1'b0;
                        IFID_write = 1'b0;
                        IDEX_flush = 1'b1;
                        state_d    = LU_STALL;
                    end
                end
                LU_STALL: state_d = RUN;
                FLUSH: begin
                    IFID_flush  = 1'b1;
                    IDEX_flush  = 1'b1;
                    flush_cnt_d = flush_cnt_q + 2'd1;
                    if (flush_cnt_d >= FLUSH_N) begin
                        state_d     = RUN;
                        flush_cnt_d = '0;
                    end
                end
                MEM_WAIT: state_d = RUN;
                default:  state_d = RUN;
            endcase
        end

        if (!rst) begin
            PC_write   = 1'b0;
            IFID_write = 1'b0;
            IDEX_write = 1'b0;
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
        end
    end

    assign state       = state_q;
    assign timeout_err = timeout_q;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!PC_write && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (FLUSH_CYCLES=3, MEM_TIMEOUT=15); stimulus pushes
// expected outputs per cycle, a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_Mread, ex_branch_taken, mem_busy;
    logic        PC_write, IFID_write, IDEX_write, IFID_flush, IDEX_flush;
    logic [1:0]  state;
    logic        timeout_err;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .FLUSH_CYCLES(3),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .ex_Mread       (ex_Mread),
        .ex_rt          (ex_rt),
        .ex_branch_taken(ex_branch_taken),
        .mem_busy       (mem_busy),
        .PC_write       (PC_write),
        .IFID_write     (IFID_write),
        .IDEX_write     (IDEX_write),
        .IFID_flush     (IFID_flush),
        .IDEX_flush     (IDEX_flush),
        .state          (state),
        .timeout_err    (timeout_err),
        .stall_count    (stall_count)
    );

    // Expected-vector layout: {PC_write, IFID_write, IDEX_write, IFID_flush, IDEX_flush, state[1:0], timeout_err}
    localparam logic [7:0] RSTV  = 8'b00011000;
    localparam logic [7:0] RUNV  = 8'b11100000;
    localparam logic [7:0] LUV   = 8'b00101000;
    localparam logic [7:0] LUSV  = 8'b11100010;
    localparam logic [7:0] BRV   = 8'b11111000;
    localparam logic [7:0] FLV   = 8'b11111100;
    localparam logic [7:0] BSY0  = 8'b00000000;
    localparam logic [7:0] BSY3  = 8'b00000110;
    localparam logic [7:0] MWREL = 8'b11100110;
`ifdef HAZARD_STATS_EN
    localparam logic [15:0] STATS7 = 16'd7;
`else
    localparam logic [15:0] STATS7 = 16'd0;
`endif

    logic [23:0] act;
    assign act = {PC_write, IFID_write, IDEX_write, IFID_flush, IDEX_flush, state, timeout_err, stall_count};

    logic [23:0] exp_q[$];
    logic [23:0] mask_q[$];
    string       name_q[$];
    int          compared   = 0;
    int          mismatched = 0;

    always @(negedge clk) begin : monitor
        logic [23:0] e, m;
        string       n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            m = mask_q.pop_front();
            n = name_q.pop_front();
            compared++;
            if (((act ^ e) & m) != 24'd0) begin
                mismatched++;
                $display("FAIL %s: got %h required %h (mask %h) at %0t", n, act, e, m, $time);
            end
        end
    end

    task automatic cyc(input string nm, input logic r,
                       input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                       input logic mr, input logic [4:0] xrt, input logic br, input logic busy,
                       input logic [7:0] v, input logic chk, input logic [15:0] cnt);
        rst             = r;
        id_rs           = rs;
        id_rt           = rt;
        id_uses_rt      = uses;
        ex_Mread        = mr;
        ex_rt           = xrt;
        ex_branch_taken = br;
        mem_busy        = busy;
        exp_q.push_back({v, cnt});
        mask_q.push_back({8'hFF, chk ? 16'hFFFF : 16'h0000});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
        ex_Mread = 1'b0; ex_rt = '0; ex_branch_taken = 1'b0; mem_busy = 1'b0;
        @(posedge clk);
        #1;
        //      name           r  rs rt u  mr xrt br bz  vec    chk cnt
        cyc("reset0",         0, 0, 0, 0, 0, 0, 0, 0, RSTV,  1, 16'd0);
        cyc("reset1",         0, 0, 0, 0, 0, 0, 0, 0, RSTV,  1, 16'd0);
        cyc("idle",           1, 0, 0, 0, 0, 0, 0, 0, RUNV,  1, 16'd0);
        cyc("lu_rs",          1, 5, 0, 0, 1, 5, 0, 0, LUV,   0, 16'd0);
        cyc("lu_rs_hold",     1, 5, 0, 0, 1, 5, 0, 0, LUSV,  0, 16'd0);
        cyc("lu_rs_ret",      1, 0, 0, 0, 0, 0, 0, 0, RUNV,  0, 16'd0);
        cyc("lu_rt",          1, 3, 7, 1, 1, 7, 0, 0, LUV,   0, 16'd0);
        cyc("lu_rt_hold",     1, 0, 0, 0, 0, 0, 0, 0, LUSV,  0, 16'd0);
        cyc("rt_not_used",    1, 3, 7, 0, 1, 7, 0, 0, RUNV,  0, 16'd0);
        cyc("r0_load",        1, 0, 0, 0, 1, 0, 0, 0, RUNV,  0, 16'd0);
        cyc("r0_next",        1, 0, 0, 0, 0, 0, 0, 0, RUNV,  0, 16'd0);
        cyc("no_mread",       1, 5, 0, 0, 0, 5, 0, 0, RUNV,  0, 16'd0);
        cyc("lu_3",           1, 9, 0, 0, 1, 9, 0, 0, LUV,   0, 16'd0);
        cyc("lu_3_hold",      1, 0, 0, 0, 0, 0, 0, 0, LUSV,  0, 16'd0);
        cyc("br_det",         1, 0, 0, 0, 0, 0, 1, 0, BRV,   0, 16'd0);
        cyc("br_fl1",         1, 0, 0, 0, 0, 0, 0, 0, FLV,   0, 16'd0);
        cyc("br_fl2",         1, 0, 0, 0, 0, 0, 0, 0, FLV,   0, 16'd0);
        cyc("br_done",        1, 0, 0, 0, 0, 0, 0, 0, RUNV,  0, 16'd0);
        cyc("brr_det",        1, 0, 0, 0, 0, 0, 1, 0, BRV,   0, 16'd0);
        cyc("brr_fl1",        1, 0, 0, 0, 0, 0, 0, 0, FLV,   0, 16'd0);
        cyc("brr_restart",    1, 0, 0, 0, 0, 0, 1, 0, FLV,   0, 16'd0);
        cyc("brr_fl2",        1, 0, 0, 0, 0, 0, 0, 0, FLV,   0, 16'd0);
        cyc("brr_fl3",        1, 0, 0, 0, 0, 0, 0, 0, FLV,   0, 16'd0);
        cyc("brr_done",       1, 0, 0, 0, 0, 0, 0, 0, RUNV,  0, 16'd0);
        cyc("br_over_lu",     1, 5, 0, 0, 1, 5, 1, 0, BRV,   0, 16'd0);
        cyc("bl_fl1",         1, 0, 0, 0, 0, 0, 0, 0, FLV,   0, 16'd0);
        cyc("bl_fl2",         1, 0, 0, 0, 0, 0, 0, 0, FLV,   0, 16'd0);
        cyc("bl_done",        1, 0, 0, 0, 0, 0, 0, 0, RUNV,  0, 16'd0);
        cyc("prio_all",       1, 5, 0, 0, 1, 5, 1, 1, BSY0,  0, 16'd0);
        cyc("mw_1",           1, 0, 0, 0, 0, 0, 0, 1, BSY3,  0, 16'd0);
        cyc("mw_2",           1, 0, 0, 0, 0, 0, 0, 1, BSY3,  0, 16'd0);
        cyc("mw_3",           1, 0, 0, 0, 0, 0, 0, 1, BSY3,  0, 16'd0);
        cyc("mw_release",     1, 0, 0, 0, 0, 0, 0, 0, MWREL, 0, 16'd0);
        cyc("stats",          1, 0, 0, 0, 0, 0, 0, 0, RUNV,  1, STATS7);
        cyc("to_enter",       1, 0, 0, 0, 0, 0, 0, 1, BSY0,  0, 16'd0);
        for (int k = 0; k < 15; k++)
            cyc("to_wait",    1, 0, 0, 0, 0, 0, 0, 1, BSY3,  0, 16'd0);
        cyc("to_flag",        1, 0, 0, 0, 0, 0, 0, 1, BSY0 | 8'd1, 0, 16'd0);
        for (int k = 0; k < 3; k++)
            cyc("to_rewait",  1, 0, 0, 0, 0, 0, 0, 1, BSY3 | 8'd1, 0, 16'd0);
        cyc("to_release",     1, 0, 0, 0, 0, 0, 0, 0, MWREL | 8'd1, 0, 16'd0);
        cyc("to_sticky",      1, 0, 0, 0, 0, 0, 0, 0, RUNV | 8'd1,  0, 16'd0);
        cyc("to_rst",         0, 0, 0, 0, 0, 0, 0, 0, RSTV,  1, 16'd0);
        cyc("to_cleared",     1, 0, 0, 0, 0, 0, 0, 0, RUNV,  1, 16'd0);
        cyc("fa_det",         1, 0, 0, 0, 0, 0, 1, 0, BRV,   0, 16'd0);
        cyc("fa_fl",          1, 0, 0, 0, 0, 0, 0, 0, FLV,   0, 16'd0);
        cyc("fa_rst",         0, 0, 0, 0, 0, 0, 0, 0, RSTV,  0, 16'd0);
        cyc("fa_run",         1, 0, 0, 0, 0, 0, 0, 0, RUNV,  0, 16'd0);
        cyc("ma_busy",        1, 0, 0, 0, 0, 0, 0, 1, BSY0,  0, 16'd0);
        cyc("ma_wait",        1, 0, 0, 0, 0, 0, 0, 1, BSY3,  0, 16'd0);
        cyc("ma_rst",         0, 0, 0, 0, 0, 0, 0, 1, RSTV,  0, 16'd0);
        cyc("ma_run",         1, 0, 0, 0, 0, 0, 0, 0, RUNV,  1, 16'd0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, legal 1..3: number of consecutive cycles the IF/ID and ID/EX flushes are held after a taken branch.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, legal 2..255: number of consecutive MEM_WAIT cycles before the timeout error is raised.
REQ-003 SHALL have clk  input  1: single clock; all state updates on posedge.
REQ-004 SHALL have rst  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have id_rs  input  5: rs field of the instruction in ID.
REQ-006 SHALL have id_rt  input  5: rt field of the instruction in ID.
REQ-007 SHALL have id_uses_rt  input  1: the ID instruction reads rt as a source.
REQ-008 SHALL have ex_Mread  input  1: ID/EX Mread output (load in EX).
REQ-009 SHALL have ex_rt  input  5: ID/EX rt output (load destination).
REQ-010 SHALL have ex_branch_taken  input  1: branch resolved taken in EX this cycle.
REQ-011 SHALL have mem_busy  input  1: data memory cannot accept or complete an access this cycle.
REQ-012 SHALL have PC_write, IFID_write, IDEX_write  output  1 each: write enables for PC and the IF/ID and ID/EX pipeline registers.
REQ-013 SHALL have IFID_flush, IDEX_flush  output  1 each: clear requests for the IF/ID and ID/EX pipeline registers.
REQ-014 SHALL have state  output  2: current FSM state (RUN=0, LU_STALL=1, FLUSH=2, MEM_WAIT=3).
REQ-015 SHALL have timeout_err  output  1: sticky memory-timeout flag.
REQ-016 SHALL have stall_count  output  16: stall-cycle statistic (see Configuration).

Function
REQ-017 SHALL register state and counters on posedge clk; outputs SHALL be combinational from the current state and current inputs (zero-cycle response).
REQ-018 SHALL define load_use = ex_Mread && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt)).
REQ-019 SHALL apply the priority mem_busy > ex_branch_taken > load_use in every state.
REQ-020 SHALL, when mem_busy = 1 in any state: drive all three write enables to 0 and both flushes to 0; next state MEM_WAIT.
REQ-021 SHALL, in MEM_WAIT with mem_busy = 0: drive all write enables to 1 and both flushes to 0; next state RUN; clear the wait counter.
REQ-022 SHALL count consecutive MEM_WAIT cycles; when the count reaches MEM_TIMEOUT, it SHALL set timeout_err = 1 (sticky until reset), force next state RUN, and clear the counter.
REQ-023 SHALL, on ex_branch_taken = 1 with mem_busy = 0: drive PC_write = 1, IFID_write = 1, IDEX_write = 1, IFID_flush = 1 and IDEX_flush = 1; next state FLUSH if FLUSH_CYCLES > 1, else RUN.
REQ-024 SHALL, in FLUSH: hold both flushes and all write enables at 1 until FLUSH_CYCLES total flush cycles, counting the detection cycle, have elapsed, then go to RUN; a new taken branch in FLUSH SHALL restart the flush count.
REQ-025 SHALL, on load_use in RUN with no higher-priority event: drive PC_write = 0, IFID_write = 0, IDEX_write = 1, IDEX_flush = 1 (bubble) and IFID_flush = 0; next state LU_STALL.
REQ-026 SHALL, in LU_STALL: ignore load_use, drive all write enables to 1 and both flushes to 0, and return to RUN after exactly one cycle.
REQ-027 SHALL, in RUN with no event: drive all write enables to 1 and both flushes to 0.

Reset
REQ-028 SHALL, while rst = 0: force state RUN, clear all counters, clear timeout_err and stall_count, drive all write enables to 0 and both flushes to 1.
REQ-029 SHALL, on rst release, resume RUN behaviour on the first posedge clk; reset asserted mid-FLUSH or mid-MEM_WAIT SHALL abort the operation immediately.

Configuration
REQ-030 SHALL support macro HAZARD_STATS_EN: when defined, stall_count increments each posedge on which PC_write = 0 and rst = 1, saturating at 16'hFFFF; when undefined, the stall_count port SHALL exist and be tied to 0 with no counter logic.

Verification
REQ-031 SHALL cover load-use: ex_Mread = 1, ex_rt = 5, id_rs = 5 -> in that cycle PC_write = 0, IFID_write = 0, IDEX_flush = 1; next cycle state = 1 with all writes at 1; following cycle state = 0.
REQ-032 SHALL cover the register-zero case: ex_Mread = 1, ex_rt = 0, id_rs = 0 -> no stall, state stays 0.
REQ-033 SHALL cover a branch with FLUSH_CYCLES = 3: ex_branch_taken pulsed for 1 cycle -> IFID_flush = IDEX_flush = 1 for exactly 3 cycles, then state = 0.
REQ-034 SHALL cover priority: mem_busy = 1, ex_branch_taken = 1 and load_use all in the same cycle -> all writes 0, flushes 0, next state = 3.
REQ-035 SHALL cover timeout: mem_busy held at 1 for 20 cycles with MEM_TIMEOUT = 15 -> timeout_err rises after the 15th MEM_WAIT cycle and remains 1 until rst = 0.
REQ-036 SHALL cover statistics: with HAZARD_STATS_EN, 3 load-use stalls plus 4 busy cycles -> stall_count = 7; without the macro -> stall_count = 0.
